// File: rtl/credit_arbiter.sv
// Round-robin arbiter sharing one credit pool; a request too large to serve
// blocks the others (HOLD) until the pool has enough credits for it.
//
// Ports:
//   CLK, nRST        clock, synchronous active-low reset
//   req_valid        per-requester pending flag
//   req_amt          per-requester amount, requester i at [i*AMT_SZ +: AMT_SZ]
//   grant            one-hot grant, combinational, same cycle as the decision
//   release__ENA     return release_v credits this cycle
//   release_v        number of credits returned
//   release__RDY     always 1
//   credits          registered credit count
//   positive         registered (credits_next > 0)
//   holding          1 while a large request is being held
//   err              sticky error flag
//
// Optional feature: define CREDIT_ARB_OVF_CHECK_EN to saturate the pool at
// MAX_CREDITS, skip requests larger than MAX_CREDITS and report both on err.
// Without it the counter wraps and err is tied to 0.
module credit_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int COUNT_SZ     = 10,
    parameter int AMT_SZ       = 4,
    parameter int INIT_CREDITS = 8,
    parameter int MAX_CREDITS  = 8
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*AMT_SZ-1:0] req_amt,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      release__ENA,
    input  logic [COUNT_SZ-1:0]       release_v,
    output logic                      release__RDY,
    output logic [COUNT_SZ-1:0]       credits,
    output logic                      positive,
    output logic                      holding,
    output logic                      err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // An INIT above capacity is a configuration error; clamp it.
    localparam int RST_INT =
        (INIT_CREDITS > MAX_CREDITS) ? MAX_CREDITS : INIT_CREDITS;
    localparam logic [COUNT_SZ-1:0] RST_CREDITS = COUNT_SZ'(RST_INT);

    logic [0:0]          state;
    logic [0:0]          state_n;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_n;
    logic [PTR_W-1:0]    hold_idx;
    logic [PTR_W-1:0]    hold_n;

    logic                cand_found;
    logic [PTR_W-1:0]    cand_idx;
    logic [PTR_W:0]      scan_idx;

    logic [PTR_W-1:0]    sel_idx;
    logic [AMT_SZ-1:0]   sel_amt;
    logic [COUNT_SZ-1:0] amt_ext;
    logic                amt_bad;
    logic                do_grant;

    logic [COUNT_SZ-1:0] rel_amt;
    logic [COUNT_SZ-1:0] take_amt;
    logic [COUNT_SZ-1:0] credits_next;

    function automatic logic [PTR_W-1:0] nxt_idx(
        input logic [PTR_W-1:0] i
    );
        if (i == PTR_W'(NUM_REQ - 1))
            return '0;
        return i + 1'b1;
    endfunction

    // First valid requester at or after ptr, wrapping mod NUM_REQ.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(NUM_REQ))
                scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
            if (!cand_found && req_valid[scan_idx[PTR_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    // In HOLD only the held requester is ever considered.
    assign sel_idx = (state == HOLD) ? hold_idx : cand_idx;
    assign sel_amt = req_amt[sel_idx*AMT_SZ +: AMT_SZ];
    assign amt_ext = COUNT_SZ'(sel_amt);

`ifdef CREDIT_ARB_OVF_CHECK_EN
    localparam logic [COUNT_SZ-1:0] MAX_C = COUNT_SZ'(MAX_CREDITS);
    assign amt_bad = (amt_ext > MAX_C);
`else
    assign amt_bad = 1'b0;
`endif

    always_comb begin
        do_grant = 1'b0;
        state_n  = state;
        hold_n   = hold_idx;
        ptr_n    = ptr;
        unique case (state)
            IDLE: begin
                if (cand_found) begin
                    if (amt_bad) begin
                        // Unservable amount: skip it rather than deadlock.
                        ptr_n = nxt_idx(cand_idx);
                    end else if (amt_ext <= credits) begin
                        do_grant = 1'b1;
                        ptr_n    = nxt_idx(cand_idx);
                    end else begin
                        state_n = HOLD;
                        hold_n  = cand_idx;
                    end
                end
            end
            HOLD: begin
                if (!req_valid[hold_idx]) begin
                    state_n = IDLE;
                end else if (amt_ext <= credits) begin
                    do_grant = 1'b1;
                    ptr_n    = nxt_idx(hold_idx);
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign grant = (do_grant && nRST)
                 ? (NUM_REQ'(1) << sel_idx)
                 : '0;

    assign rel_amt  = release__ENA ? release_v : '0;
    assign take_amt = do_grant ? amt_ext : '0;

`ifdef CREDIT_ARB_OVF_CHECK_EN
    // One extra bit so an overshoot is seen before it wraps.
    logic [COUNT_SZ:0] sum_w;
    logic              ovf;
    logic              skip_err;
    logic              err_q;

    assign sum_w = {1'b0, credits} + {1'b0, rel_amt}
                 - {1'b0, take_amt};
    assign ovf   = (sum_w > {1'b0, MAX_C});
    assign credits_next = ovf ? MAX_C : sum_w[COUNT_SZ-1:0];
    assign skip_err = (state == IDLE) && cand_found && amt_bad;

    always_ff @(posedge CLK) begin
        if (!nRST)
            err_q <= 1'b0;
        else
            err_q <= err_q | ovf | skip_err;
    end

    assign err = err_q;
`else
    assign credits_next = credits + rel_amt - take_amt;
    assign err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            credits  <= RST_CREDITS;
            positive <= (RST_CREDITS != '0);
            ptr      <= '0;
            state    <= IDLE;
            hold_idx <= '0;
        end else begin
            credits  <= credits_next;
            positive <= (credits_next != '0);
            ptr      <= ptr_n;
            state    <= state_n;
            hold_idx <= hold_n;
        end
    end

    assign holding      = (state == HOLD);
    assign release__RDY = 1'b1;

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed bench for credit_arbiter: a vector table applied cycle by cycle
// plus a hand-written reset-during-HOLD sequence.
module tb_credit_arbiter;

`ifdef CREDIT_ARB_OVF_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        CLK;
    logic        nRST;
    logic [3:0]  req_valid;
    logic [15:0] req_amt;
    logic [3:0]  grant;
    logic        release__ENA;
    logic [9:0]  release_v;
    logic        release__RDY;
    logic [9:0]  credits;
    logic        positive;
    logic        holding;
    logic        err;

    int checks;
    int errors;

    credit_arbiter #(
        .NUM_REQ(4), .COUNT_SZ(10), .AMT_SZ(4),
        .INIT_CREDITS(8), .MAX_CREDITS(8)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .req_valid(req_valid),
        .req_amt(req_amt),
        .grant(grant),
        .release__ENA(release__ENA),
        .release_v(release_v),
        .release__RDY(release__RDY),
        .credits(credits),
        .positive(positive),
        .holding(holding),
        .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rn;
        logic [3:0]  v;
        logic [15:0] a;
        logic        re;
        logic [9:0]  rv;
        logic [3:0]  g;
        logic [9:0]  c;
        logic        h;
        logic        e;
    } vec_t;

    vec_t tv[19];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic [3:0] v,
                         input logic [15:0] a, input logic re,
                         input logic [9:0] rv);
        nRST         = rn;
        req_valid    = v;
        req_amt      = a;
        release__ENA = re;
        release_v    = rv;
    endtask

    task automatic chk_state(input string tag,
                             input logic [3:0] g,
                             input logic [9:0] c,
                             input logic h, input logic e);
        chk({tag, " grant"},   32'(grant),    32'(g));
        chk({tag, " credits"}, 32'(credits),  32'(c));
        chk({tag, " pos"},     32'(positive), 32'(c != 10'd0));
        chk({tag, " hold"},    32'(holding),  32'(h));
        chk({tag, " err"},     32'(err),      32'(e));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // rn valid  amt       re rv     grant   cred  hold err
        tv[0]  = '{1'b1, 4'b0011, 16'h0022, 1'b0, 10'd0,
                   4'b0001, 10'd8, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 4'b0011, 16'h0022, 1'b0, 10'd0,
                   4'b0010, 10'd6, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 4'b0011, 16'h0022, 1'b0, 10'd0,
                   4'b0001, 10'd4, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 4'b0011, 16'h0022, 1'b0, 10'd0,
                   4'b0010, 10'd2, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 4'b0011, 16'h0022, 1'b0, 10'd0,
                   4'b0000, 10'd0, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 4'b0011, 16'h0022, 1'b0, 10'd0,
                   4'b0000, 10'd0, 1'b1, 1'b0};
        // abort the hold, then refill to 3
        tv[6]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 10'd0,
                   4'b0000, 10'd0, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 4'b0000, 16'h0000, 1'b1, 10'd3,
                   4'b0000, 10'd0, 1'b0, 1'b0};
        // ptr=2: req2 amt5 held, req0 blocked, release 2
        tv[8]  = '{1'b1, 4'b0101, 16'h0501, 1'b0, 10'd0,
                   4'b0000, 10'd3, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 4'b0101, 16'h0501, 1'b1, 10'd2,
                   4'b0000, 10'd3, 1'b1, 1'b0};
        tv[10] = '{1'b1, 4'b0101, 16'h0501, 1'b0, 10'd0,
                   4'b0100, 10'd5, 1'b1, 1'b0};
        tv[11] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 10'd4,
                   4'b0000, 10'd0, 1'b0, 1'b0};
        // grant and release together: 4 + 3 - 2
        tv[12] = '{1'b1, 4'b0010, 16'h0020, 1'b1, 10'd3,
                   4'b0010, 10'd4, 1'b0, 1'b0};
        tv[13] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 10'd0,
                   4'b0000, 10'd5, 1'b0, 1'b0};
        // zero amount still granted
        tv[14] = '{1'b1, 4'b1000, 16'h0000, 1'b0, 10'd0,
                   4'b1000, 10'd5, 1'b0, 1'b0};
        tv[15] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 10'd3,
                   4'b0000, 10'd5, 1'b0, 1'b0};
        // release past capacity
        tv[16] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 10'd1,
                   4'b0000, 10'd8, 1'b0, 1'b0};
        tv[17] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 10'd0,
                   4'b0000, CHK ? 10'd8 : 10'd9, 1'b0, CHK};
        tv[18] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 10'd0,
                   4'b0000, CHK ? 10'd8 : 10'd9, 1'b0, CHK};

        // Reset state; requests present but grant must stay 0.
        drive(1'b0, 4'b1111, 16'h1111, 1'b0, 10'd0);
        repeat (2) @(negedge CLK);
        #4;
        chk_state("reset", 4'b0000, 10'd8, 1'b0, 1'b0);
        chk("rdy", 32'(release__RDY), 32'd1);

        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            drive(tv[i].rn, tv[i].v, tv[i].a, tv[i].re, tv[i].rv);
            #4;
            chk_state($sformatf("row%0d", i),
                      tv[i].g, tv[i].c, tv[i].h, tv[i].e);
        end

        // Reset during HOLD with credits=2, then check ptr restarted at 0.
        @(negedge CLK);
        drive(1'b0, 4'b0000, 16'h0000, 1'b0, 10'd0);
        @(negedge CLK);
        drive(1'b1, 4'b0010, 16'h0060, 1'b0, 10'd0);
        #4;
        chk_state("h6a", 4'b0010, 10'd8, 1'b0, 1'b0);
        @(negedge CLK);
        drive(1'b1, 4'b0001, 16'h0005, 1'b0, 10'd0);
        #4;
        chk_state("h6b", 4'b0000, 10'd2, 1'b0, 1'b0);
        @(negedge CLK);
        #4;
        chk_state("h6c", 4'b0000, 10'd2, 1'b1, 1'b0);
        @(negedge CLK);
        drive(1'b0, 4'b0001, 16'h0005, 1'b0, 10'd0);
        #4;
        chk("h6d grant", 32'(grant), 32'd0);
        @(negedge CLK);
        drive(1'b1, 4'b0110, 16'h0110, 1'b0, 10'd0);
        #4;
        chk_state("h6e", 4'b0010, 10'd8, 1'b0, 1'b0);

`ifdef CREDIT_ARB_OVF_CHECK_EN
        // Oversized request is skipped, flags err, no HOLD.
        @(negedge CLK);
        drive(1'b1, 4'b1000, 16'h9000, 1'b0, 10'd0);
        #4;
        chk_state("big", 4'b0000, 10'd7, 1'b0, 1'b0);
        @(negedge CLK);
        drive(1'b1, 4'b0000, 16'h0000, 1'b0, 10'd0);
        #4;
        chk_state("big2", 4'b0000, 10'd7, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
